// File: rtl/multdiv_stall_unit.sv
// multdiv_stall_unit
//   Iterative signed multiply/divide engine for the execute stage. It also
//   produces the stall that freezes PC/FD/DX while an operation computes.
//   A mul/div sitting in DX starts the engine. The engine runs one
//   shift-add or restoring-divide step per cycle, then presents the result
//   and error flag for one cycle so XM can capture them.
//
// Ports
//   clock           system clock, all state on the rising edge
//   reset           synchronous, active-high
//   DX_Latch_Instr  instruction currently in DX
//   ALU_A_operand   post-bypass operand A (rs)
//   ALU_B_operand   post-bypass operand B (rt)
//   stall_pipeline  hold PC/FD/DX, insert nop into XM
//   result          product / quotient, or rstatus code on exception
//   result_valid    result is valid this cycle
//   exception       error flag for the XM error-flag latch
//   busy            engine is iterating
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a mul/div in DX; stall follows the decode directly
// BUSY  | one arithmetic step per cycle, pipeline stalled
// DONE  | result/exception registered and valid for exactly one cycle

module multdiv_stall_unit #(
  parameter int          ITERATIONS  = 32,
  parameter logic [31:0] MUL_RSTATUS = 32'd4,
  parameter logic [31:0] DIV_RSTATUS = 32'd5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] DX_Latch_Instr,
  input  logic [31:0] ALU_A_operand,
  input  logic [31:0] ALU_B_operand,
  output logic        stall_pipeline,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        exception,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam int            CW   = $clog2(ITERATIONS);
  localparam logic [CW-1:0] LAST = CW'(ITERATIONS - 1);

  state_t        state, state_next;
  logic [CW-1:0] count;
  logic [63:0]   acc;        // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [31:0]   operand;    // mul: |A| multiplicand; div: |B| divisor
  logic          sign_result;
  logic          op_is_div;

  logic [4:0]  opcode, alu_op;
  logic        is_mul, is_div, start_cond, div_by_zero;
  logic [31:0] abs_a, abs_b;

  logic [32:0] mul_sum;
  logic [32:0] div_shift, div_sub;
  logic        div_fits;
  logic [63:0] acc_next, prod_signed;
  logic [31:0] quot_signed;
  logic        mul_ovf;
  logic        unused_bits;

  assign opcode      = DX_Latch_Instr[31:27];
  assign alu_op      = DX_Latch_Instr[6:2];
  assign is_mul      = (opcode == 5'd0) && (alu_op == 5'd6);
  assign is_div      = (opcode == 5'd0) && (alu_op == 5'd7);
  assign start_cond  = (is_mul || is_div) && (state == S_IDLE);
  assign div_by_zero = is_div && (ALU_B_operand == 32'd0);

  // 0x80000000 negates to itself, which reads correctly as unsigned 2^31.
  assign abs_a = ALU_A_operand[31] ? -ALU_A_operand : ALU_A_operand;
  assign abs_b = ALU_B_operand[31] ? -ALU_B_operand : ALU_B_operand;

  // One step of each algorithm. Only the one selected by op_is_div is used.
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
    div_shift = {acc[63:32], acc[31]};
    div_sub   = div_shift - {1'b0, operand};
    div_fits  = (div_shift >= {1'b0, operand});
    if (op_is_div)
      acc_next = div_fits ? {div_sub[31:0], acc[30:0], 1'b1}
                          : {div_shift[31:0], acc[30:0], 1'b0};
    else
      acc_next = {mul_sum, acc[31:1]};
    prod_signed = sign_result ? -acc_next : acc_next;
    quot_signed = sign_result ? -acc_next[31:0] : acc_next[31:0];
    mul_ovf     = (prod_signed[63:32] != {32{prod_signed[31]}});
  end

  // Bit 32 of the subtraction is never needed: div_fits already gives the borrow.
  assign unused_bits = ^{DX_Latch_Instr[26:7], DX_Latch_Instr[1:0], div_sub[32]};

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next     = state;
    stall_pipeline = 1'b0;
    busy           = 1'b0;
    result_valid   = 1'b0;
    case (state)
      S_IDLE: begin
        stall_pipeline = start_cond;
        if (start_cond) state_next = div_by_zero ? S_DONE : S_BUSY;
      end
      S_BUSY: begin
        stall_pipeline = 1'b1;
        busy           = 1'b1;
        if (count == LAST) state_next = S_DONE;
      end
      S_DONE: begin
        // DX still holds the completing instruction here, so no start decode.
        result_valid = 1'b1;
        state_next   = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count       <= '0;
      acc         <= '0;
      operand     <= '0;
      sign_result <= 1'b0;
      op_is_div   <= 1'b0;
      result      <= '0;
      exception   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_cond) begin
            count       <= '0;
            sign_result <= ALU_A_operand[31] ^ ALU_B_operand[31];
            op_is_div   <= is_div;
            operand     <= is_div ? abs_b : abs_a;
            acc         <= {32'd0, is_div ? abs_a : abs_b};
            if (div_by_zero) begin
              result    <= DIV_RSTATUS;
              exception <= 1'b1;
            end
          end
        end
        S_BUSY: begin
          acc   <= acc_next;
          count <= count + 1'b1;
          if (count == LAST) begin
            if (op_is_div) begin
              result    <= quot_signed;
              exception <= 1'b0;
            end else begin
              result    <= mul_ovf ? MUL_RSTATUS : prod_signed[31:0];
              exception <= mul_ovf;
            end
          end
        end
        default: count <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_stall_unit.sv
// Testbench for multdiv_stall_unit: scoreboard of expected results computed
// from plain 64-bit signed arithmetic, compared when result_valid appears.

module tb_multdiv_stall_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] DX_Latch_Instr, ALU_A_operand, ALU_B_operand;
  logic        stall_pipeline, result_valid, exception, busy;
  logic [31:0] result;

  multdiv_stall_unit dut (
    .clock(clock), .reset(reset), .DX_Latch_Instr(DX_Latch_Instr),
    .ALU_A_operand(ALU_A_operand), .ALU_B_operand(ALU_B_operand),
    .stall_pipeline(stall_pipeline), .result(result), .result_valid(result_valid),
    .exception(exception), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          stalls;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  localparam logic [31:0] NOP = 32'h0;

  function automatic logic [31:0] mk(input logic [4:0] opc, input logic [4:0] aop);
    return {opc, 5'd3, 5'd1, 5'd2, 5'd0, aop, 2'b00};
  endfunction

  function automatic exp_t model(input bit div, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint p;
    e.exc    = 1'b0;
    e.stalls = 33;
    if (!div) begin
      p     = longint'($signed(a)) * longint'($signed(b));
      e.res = p[31:0];
      if (p != longint'($signed(p[31:0]))) begin
        e.exc = 1'b1;
        e.res = 32'd4;
      end
    end else if (b == 32'd0) begin
      e.res    = 32'd5;
      e.exc    = 1'b1;
      e.stalls = 1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.res = a;
    end else begin
      e.res = $signed(a) / $signed(b);
    end
    return e;
  endfunction

  // Puts an op into DX at the next negedge, pushes its expectation and waits
  // for result_valid, counting stall cycles. Returns with DX still holding the
  // op during the DONE cycle.
  task automatic run_op(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                        input bit toggle, output logic [31:0] res, output logic exc,
                        output int stalls, output logic done_stall, output bit timeout);
    @(negedge clock);
    DX_Latch_Instr = instr;
    ALU_A_operand  = a;
    ALU_B_operand  = b;
    sb.push_back(model(instr[6:2] == 5'd7, a, b));
    stalls     = 0;
    timeout    = 1'b1;
    res        = '0;
    exc        = 1'b0;
    done_stall = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (result_valid) begin
        res        = result;
        exc        = exception;
        done_stall = stall_pipeline | busy;
        timeout    = 1'b0;
        break;
      end
      if (stall_pipeline) stalls++;
      @(negedge clock);
      if (toggle) begin
        ALU_A_operand = $urandom;
        ALU_B_operand = $urandom;
      end
    end
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    DX_Latch_Instr = NOP;
    ALU_A_operand  = '0;
    ALU_B_operand  = '0;
    repeat (2) @(negedge clock);
    #1;
    vectors++;
    if ({stall_pipeline, result_valid, exception, busy, result} !== 36'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: stall=%b valid=%b exc=%b busy=%b result=%h, required all 0",
               stall_pipeline, result_valid, exception, busy, result);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_ops(input string name, input logic [4:0] aop,
                          input logic [31:0] as[], input logic [31:0] bs[]);
    logic [31:0] r; logic x, ds; int st; bit to; exp_t e;
    for (int i = 0; i < as.size(); i++) begin
      run_op(mk(5'd0, aop), as[i], bs[i], 1'b0, r, x, st, ds, to);
      e = sb.pop_front();
      vectors++;
      if (to || r !== e.res || x !== e.exc) begin
        miscompares++;
        $display("FAIL %s[%0d] %h,%h: result=%h exc=%b timeout=%b, required result=%h exc=%b",
                 name, i, as[i], bs[i], r, x, to, e.res, e.exc);
      end
      vectors++;
      if (st !== e.stalls || ds !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_stall[%0d]: stall cycles=%0d done_stall=%b, required %0d and 0",
                 name, i, st, ds, e.stalls);
      end
    end
    @(negedge clock);
    DX_Latch_Instr = NOP;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; logic x, ds; int st; bit to; exp_t e;
    logic [31:0] as[3] = '{32'd12, 32'hFFFF_FFF0, 32'd1000};
    logic [31:0] bs[3] = '{32'd11, 32'd3, 32'hFFFF_FC18};
    for (int i = 0; i < 3; i++) begin
      run_op(mk(5'd0, 5'd6), as[i], bs[i], 1'b1, r, x, st, ds, to);
      e = sb.pop_front();
      vectors++;
      if (to || r !== e.res || x !== e.exc || st !== e.stalls || ds !== 1'b0) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: result=%h exc=%b stalls=%0d done_stall=%b timeout=%b, required result=%h exc=%b stalls=%0d",
                 i, r, x, st, ds, to, e.res, e.exc, e.stalls);
      end
    end
    #1;
    vectors++;
    if (stall_pipeline !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL no_relaunch: stall=%b busy=%b in DONE, required 0 0", stall_pipeline, busy);
    end
    @(negedge clock);
    DX_Latch_Instr = NOP;
  endtask

  task automatic test_non_muldiv();
    logic [31:0] instrs[3];
    instrs[0] = mk(5'd0, 5'd0);
    instrs[1] = mk(5'd8, 5'd6);
    instrs[2] = mk(5'd1, 5'd7);
    foreach (instrs[i]) begin
      @(negedge clock);
      DX_Latch_Instr = instrs[i];
      ALU_A_operand  = 32'd5;
      ALU_B_operand  = 32'd0;
      for (int c = 0; c < 3; c++) begin
        #1;
        vectors++;
        if ({stall_pipeline, busy, result_valid} !== 3'b000) begin
          miscompares++;
          $display("FAIL non_muldiv[%0d]: stall=%b busy=%b valid=%b, required 0 0 0",
                   i, stall_pipeline, busy, result_valid);
        end
        @(negedge clock);
      end
    end
    DX_Latch_Instr = NOP;
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] r; logic x, ds; int st; bit to; exp_t e;
    @(negedge clock);
    DX_Latch_Instr = mk(5'd0, 5'd6);
    ALU_A_operand  = 32'd100;
    ALU_B_operand  = 32'd200;
    repeat (11) @(negedge clock);
    #1;
    vectors++;
    if (busy !== 1'b1 || stall_pipeline !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_busy: busy=%b stall=%b, required 1 1", busy, stall_pipeline);
    end
    reset          = 1'b1;
    DX_Latch_Instr = NOP;
    @(negedge clock);
    reset = 1'b0;
    #1;
    vectors++;
    if ({stall_pipeline, busy, result_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_mid_op: stall=%b busy=%b valid=%b, required 0 0 0",
               stall_pipeline, busy, result_valid);
    end
    run_op(mk(5'd0, 5'd6), 32'd3, 32'd3, 1'b0, r, x, st, ds, to);
    e = sb.pop_front();
    vectors++;
    if (to || r !== e.res || x !== e.exc || st !== e.stalls) begin
      miscompares++;
      $display("FAIL after_reset_mul: result=%h exc=%b stalls=%0d timeout=%b, required result=%h exc=%b stalls=%0d",
               r, x, st, to, e.res, e.exc, e.stalls);
    end
    @(negedge clock);
    DX_Latch_Instr = NOP;
  endtask

  initial begin
    test_reset();
    test_ops("mul", 5'd6,
             '{32'd7, 32'h0001_0000, 32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'h0000_B504},
             '{32'hFFFF_FFFA, 32'h0001_0000, 32'hFFFF_FFF9, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'h0000_B504});
    test_ops("div", 5'd7,
             '{32'hFFFF_FFEF, 32'h8000_0000, 32'd100, 32'hFFFF_FF9C, 32'd3, 32'h7FFF_FFFF},
             '{32'd5, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF9, 32'd10, 32'h8000_0000});
    test_ops("div_zero", 5'd7, '{32'd9, 32'hFFFF_FFF7}, '{32'd0, 32'd0});
    test_back_to_back();
    test_non_muldiv();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multdiv_stall_unit.md
Name: multdiv_stall_unit

Overview:
- Execute-stage iterative multiply/divide engine with its own pipeline-stall controller.
- Sits directly downstream of the bypass/hazard select logic and consumes the post-bypass ALU A/B operands.
- Stalls PC, FD and DX latches while a mul/div in DX is computing, then presents the result and error flag for capture into the XM latch and XM error-flag latch.

Parameters:
- ITERATIONS, 32, shift-add / restoring-divide steps per operation; must equal the operand width.
- MUL_RSTATUS, 32'd4, value sent to $r30 on multiply overflow.
- DIV_RSTATUS, 32'd5, value sent to $r30 on divide by zero.

Ports:
- clock  input  1  single system clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- DX_Latch_Instr  input  32  instruction currently in DX.
- ALU_A_operand  input  32  post-bypass/exception-mux operand A (rs).
- ALU_B_operand  input  32  post-bypass/exception-mux operand B (rt).
- stall_pipeline  output  1  hold PC/FD/DX latches, insert nop into XM.
- result  output  32  product/quotient, or rstatus value on exception.
- result_valid  output  1  result valid this cycle; XM captures it.
- exception  output  1  drives XM_ErrorFlag_Latch input.
- busy  output  1  engine in BUSY state (debug/perf).

Behaviour:
- Decode: start_cond = (opcode[31:27]==0) && (ALU_op[6:2]==6 mul || ==7 div) && state==IDLE.
- States: IDLE, BUSY, DONE.
- Reset: state=IDLE, count=0, all datapath registers 0.
- Reset outputs: stall_pipeline=0, result=0, result_valid=0, exception=0, busy=0.
- IDLE:
  - stall_pipeline = start_cond (combinational, same cycle the instruction appears in DX).
  - On an edge with start_cond: latch |A|, |B|, sign_result = A[31]^B[31], op_is_div, count=0.
  - Mul or nonzero div -> BUSY.
  - Div with B==0 -> DONE, exception latched to 1, result = DIV_RSTATUS.
- BUSY:
  - stall_pipeline=1, busy=1.
  - One shift-add (mul, 64-bit accumulator) or restoring subtract-shift (div) step per cycle; count++.
  - count==ITERATIONS-1 -> DONE.
- DONE (exactly one cycle):
  - result_valid=1, stall_pipeline=0.
  - DX_Latch_Instr is ignored for start in this state, so the completing instruction cannot relaunch.
  - Next state is IDLE unconditionally.
- Latency:
  - Normal op: stall high for ITERATIONS+1 cycles (33); result_valid in cycle 34 after the op enters DX.
  - Div-by-zero: stall for 1 cycle; result_valid in cycle 2.
- Arithmetic:
  - Signed two's complement; operate on magnitudes, negate the result if sign_result.
  - Mul: result = low 32 bits of the signed product. Overflow (exception=1, result=MUL_RSTATUS) when the high 32 bits are not the sign extension of bit 31.
  - Div: quotient truncates toward zero; remainder discarded. 0x80000000 / -1 returns 0x80000000, no exception.
  - |0x80000000| is handled as unsigned 32-bit 2^31.
- Outputs are registered in DONE: result, exception and result_valid are stable for the whole DONE cycle. result and exception hold their value in IDLE/BUSY but are qualified by result_valid.
- Back-to-back: a mul/div that enters DX in the cycle after DONE starts normally (one idle-free gap).
- Operands change while BUSY: ignored; only values latched at start are used.
- Reset mid-operation: the next edge forces IDLE, count=0, stall=0; any partial result is discarded.
- Non-mul/div instructions in DX: no effect, all outputs quiescent.

Test Plan:
- mul 7 * -6 (A=7, B=0xFFFFFFFA) -> stall high 33 cycles, then one cycle with result_valid=1, result=0xFFFFFFD6 (-42), exception=0.
- mul 0x00010000 * 0x00010000 -> after 33 stall cycles: result=4, exception=1.
- div -17 / 5 -> result=0xFFFFFFFD (-3), exception=0; div 0x80000000 / -1 -> result=0x80000000, exception=0.
- div 9 / 0 -> stall exactly 1 cycle, next cycle result_valid=1, result=5, exception=1.
- Two mul instructions back-to-back in DX -> second starts the cycle after the first's DONE, no double launch; ALU_A/B toggled during BUSY do not change results.
- Assert reset at BUSY count=10 -> next cycle stall=0, busy=0, result_valid=0. A subsequent mul 3*3 gives result 9.
